// File: rtl/exc_sequencer_pkg.sv
// Shared definitions for the exception sequencer.
// Holds the CP0 exception codes, the FSM state encoding and the EPC
// delay-slot adjustment helper.
package exc_sequencer_pkg;

    localparam logic [4:0] EC_NONE = 5'h1F;
    localparam logic [4:0] EC_ERET = 5'h1E;
    localparam logic [4:0] EC_INT  = 5'h00;
    localparam logic [4:0] EC_TLBL = 5'h02;
    localparam logic [4:0] EC_ADEL = 5'h04;
    localparam logic [4:0] EC_SYS  = 5'h08;
    localparam logic [4:0] EC_RI   = 5'h0A;
    localparam logic [4:0] EC_OV   = 5'h0C;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_JUMP = 2'd2,
        ST_FLUSH     = 2'd3
    } state_e;

    // An instruction in a branch delay slot restarts at its branch, one word
    // back. Subtraction is 32-bit modulo, so PC 0 wraps to 0xFFFFFFFC.
    function automatic logic [31:0] epc_adjust(input logic [31:0] pc,
                                               input logic        in_ds);
        return in_ds ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// Bus between the pipeline/CP0 side and the exception sequencer.
// master: pipeline + CP0 model (drives requests and jump strobe)
// slave : exc_sequencer (drives the CP0 strobe and flush/stall/busy)
interface exc_sequencer_if;
    logic [3:0]   stage_valid_i;
    logic [19:0]  stage_code_i;
    logic [127:0] stage_pc_i;
    logic [127:0] stage_badvaddr_i;
    logic         mem_valid_i;
    logic [31:0]  mem_pc_i;
    logic         mem_in_delay_slot_i;
    logic         eret_i;
    logic         has_int_i;
    logic         exc_jump_flag_i;
    logic [4:0]   exc_code_o;
    logic [31:0]  exc_epc_o;
    logic [31:0]  exc_badvaddr_o;
    logic         flush_o;
    logic         stall_o;
    logic         busy_o;

    modport master (
        output stage_valid_i, stage_code_i, stage_pc_i, stage_badvaddr_i,
               mem_valid_i, mem_pc_i, mem_in_delay_slot_i, eret_i,
               has_int_i, exc_jump_flag_i,
        input  exc_code_o, exc_epc_o, exc_badvaddr_o, flush_o, stall_o,
               busy_o
    );

    modport slave (
        input  stage_valid_i, stage_code_i, stage_pc_i, stage_badvaddr_i,
               mem_valid_i, mem_pc_i, mem_in_delay_slot_i, eret_i,
               has_int_i, exc_jump_flag_i,
        output exc_code_o, exc_epc_o, exc_badvaddr_o, flush_o, stall_o,
               busy_o
    );
endinterface

// File: rtl/exc_sequencer_prio_sel.sv
// exc_prio_sel: combinational priority picker.
// Ports: per-stage valid/code/pc/badvaddr vectors (bit3/top slice = MEM),
// MEM commit info, ERET and interrupt flags in; selected code/epc/badvaddr
// and hit out. Order: MEM, interrupt, EX, ID, IF, ERET.
module exc_prio_sel
    import exc_sequencer_pkg::*;
(
    input  logic [3:0]   stage_valid_i,
    input  logic [19:0]  stage_code_i,
    input  logic [127:0] stage_pc_i,
    input  logic [127:0] stage_badvaddr_i,
    input  logic         mem_valid_i,
    input  logic [31:0]  mem_pc_i,
    input  logic         mem_in_delay_slot_i,
    input  logic         eret_i,
    input  logic         has_int_i,
    output logic [4:0]   sel_code_o,
    output logic [31:0]  sel_epc_o,
    output logic [31:0]  sel_badvaddr_o,
    output logic         sel_hit_o
);

    always_comb begin
        sel_hit_o      = 1'b0;
        sel_code_o     = EC_NONE;
        sel_epc_o      = 32'd0;
        sel_badvaddr_o = 32'd0;
        if (stage_valid_i[3]) begin
            sel_hit_o      = 1'b1;
            sel_code_o     = stage_code_i[19:15];
            sel_epc_o      = epc_adjust(stage_pc_i[127:96], mem_in_delay_slot_i);
            sel_badvaddr_o = stage_badvaddr_i[127:96];
        end else if (has_int_i && mem_valid_i) begin
            // Interrupts are taken on the committing MEM instruction.
            sel_hit_o  = 1'b1;
            sel_code_o = EC_INT;
            sel_epc_o  = epc_adjust(mem_pc_i, mem_in_delay_slot_i);
        end else if (stage_valid_i[2]) begin
            sel_hit_o      = 1'b1;
            sel_code_o     = stage_code_i[14:10];
            sel_epc_o      = stage_pc_i[95:64];
            sel_badvaddr_o = stage_badvaddr_i[95:64];
        end else if (stage_valid_i[1]) begin
            sel_hit_o      = 1'b1;
            sel_code_o     = stage_code_i[9:5];
            sel_epc_o      = stage_pc_i[63:32];
            sel_badvaddr_o = stage_badvaddr_i[63:32];
        end else if (stage_valid_i[0]) begin
            sel_hit_o      = 1'b1;
            sel_code_o     = stage_code_i[4:0];
            sel_epc_o      = stage_pc_i[31:0];
            sel_badvaddr_o = stage_badvaddr_i[31:0];
        end else if (eret_i && mem_valid_i) begin
            sel_hit_o  = 1'b1;
            sel_code_o = EC_ERET;
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// exc_sequencer: picks one precise exception/interrupt/ERET per commit,
// strobes it into CP0 for one cycle, waits for CP0's jump strobe, then
// holds flush/stall for FLUSH_CYCLES before accepting new events.
// Ports: clk, rst (async, active-high), bus (exc_sequencer_if.slave).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | accepting requests; outputs quiet
// ISSUE      | code/EPC/BadVAddr presented to CP0 for this one cycle
// WAIT_JUMP  | waiting up to ACK_TIMEOUT cycles for exc_jump_flag_i
// FLUSH      | flush/stall held for FLUSH_CYCLES after the jump strobe
module exc_sequencer
    import exc_sequencer_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT  = 4
) (
    input  logic            clk,
    input  logic            rst,
    exc_sequencer_if.slave  bus
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] ACK_LOAD   = 4'(ACK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] bva_q, bva_d;

    logic [4:0]  sel_code;
    logic [31:0] sel_epc;
    logic [31:0] sel_bva;
    logic        sel_hit;

    exc_prio_sel u_prio_sel (
        .stage_valid_i       (bus.stage_valid_i),
        .stage_code_i        (bus.stage_code_i),
        .stage_pc_i          (bus.stage_pc_i),
        .stage_badvaddr_i    (bus.stage_badvaddr_i),
        .mem_valid_i         (bus.mem_valid_i),
        .mem_pc_i            (bus.mem_pc_i),
        .mem_in_delay_slot_i (bus.mem_in_delay_slot_i),
        .eret_i              (bus.eret_i),
        .has_int_i           (bus.has_int_i),
        .sel_code_o          (sel_code),
        .sel_epc_o           (sel_epc),
        .sel_badvaddr_o      (sel_bva),
        .sel_hit_o           (sel_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            code_q  <= EC_NONE;
            epc_q   <= 32'd0;
            bva_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            bva_q   <= bva_d;
        end
    end

    // The strobe registers default back to quiet every cycle, so they only
    // carry a value during the single ISSUE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = EC_NONE;
        epc_d   = 32'd0;
        bva_d   = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (sel_hit) begin
                    state_d = ST_ISSUE;
                    code_d  = sel_code;
                    epc_d   = sel_epc;
                    bva_d   = sel_bva;
                    cnt_d   = 4'd0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_JUMP;
                cnt_d   = ACK_LOAD;
            end
            ST_WAIT_JUMP: begin
                // A strobe on the last allowed cycle still counts.
                if (bus.exc_jump_flag_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoded straight from the state register so an async reset drops
    // them in the same cycle.
    assign bus.flush_o        = (state_q != ST_IDLE);
    assign bus.stall_o        = (state_q != ST_IDLE);
    assign bus.busy_o         = (state_q != ST_IDLE);
    assign bus.exc_code_o     = code_q;
    assign bus.exc_epc_o      = epc_q;
    assign bus.exc_badvaddr_o = bva_q;

endmodule

// File: tb/tb_exc_sequencer.sv
module tb_exc_sequencer;
    import exc_sequencer_pkg::*;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] bva;
    } exp_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    exc_sequencer_if bus ();

    exc_sequencer #(.FLUSH_CYCLES(2), .ACK_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.stage_valid_i       = 4'd0;
        bus.stage_code_i        = 20'd0;
        bus.stage_pc_i          = 128'd0;
        bus.stage_badvaddr_i    = 128'd0;
        bus.mem_valid_i         = 1'b0;
        bus.mem_pc_i            = 32'd0;
        bus.mem_in_delay_slot_i = 1'b0;
        bus.eret_i              = 1'b0;
        bus.has_int_i           = 1'b0;
        bus.exc_jump_flag_i     = 1'b0;
    endtask

    task automatic set_stage(input int s, input logic [4:0] c,
                             input logic [31:0] pc, input logic [31:0] bv);
        bus.stage_valid_i[s]         = 1'b1;
        bus.stage_code_i[s*5 +: 5]   = c;
        bus.stage_pc_i[s*32 +: 32]   = pc;
        bus.stage_badvaddr_i[s*32 +: 32] = bv;
    endtask

    task automatic push(input logic [4:0] c, input logic [31:0] epc, input logic [31:0] bv);
        exp_t e;
        e.code = c;
        e.epc  = epc;
        e.bva  = bv;
        sb.push_back(e);
    endtask

    // Bounded wait for the ISSUE cycle; compares it against the scoreboard.
    task automatic wait_issue(input string tag);
        exp_t e;
        bit   seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.exc_code_o !== EC_NONE) seen = 1'b1;
        end
        check($sformatf("%s_seen", tag), {31'd0, seen}, 32'd1);
        if (sb.size() == 0) begin
            check($sformatf("%s_sb_empty", tag), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s_code", tag), {27'd0, bus.exc_code_o}, {27'd0, e.code});
            check($sformatf("%s_epc", tag), bus.exc_epc_o, e.epc);
            check($sformatf("%s_bva", tag), bus.exc_badvaddr_o, e.bva);
            check($sformatf("%s_flush", tag), {31'd0, bus.flush_o}, 32'd1);
            check($sformatf("%s_stall", tag), {31'd0, bus.stall_o}, 32'd1);
        end
    endtask

    // From the ISSUE negedge: strobe jump on the first WAIT_JUMP cycle,
    // expect two flush cycles, then idle.
    task automatic finish_jump(input string tag);
        @(negedge clk);
        check($sformatf("%s_code_one_cycle", tag), {27'd0, bus.exc_code_o}, {27'd0, EC_NONE});
        check($sformatf("%s_epc_cleared", tag), bus.exc_epc_o, 32'd0);
        check($sformatf("%s_wait_flush", tag), {31'd0, bus.flush_o}, 32'd1);
        bus.exc_jump_flag_i = 1'b1;
        @(negedge clk);
        bus.exc_jump_flag_i = 1'b0;
        check($sformatf("%s_flush1", tag), {31'd0, bus.flush_o}, 32'd1);
        check($sformatf("%s_stall1", tag), {31'd0, bus.stall_o}, 32'd1);
        @(negedge clk);
        check($sformatf("%s_flush2", tag), {31'd0, bus.flush_o}, 32'd1);
        @(negedge clk);
        check($sformatf("%s_busy_end", tag), {31'd0, bus.busy_o}, 32'd0);
        check($sformatf("%s_flush_end", tag), {31'd0, bus.flush_o}, 32'd0);
    endtask

    // From the ISSUE negedge: no jump strobe, expect exactly four
    // WAIT_JUMP cycles before idle.
    task automatic finish_timeout(input string tag);
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.busy_o) break;
            n++;
        end
        check($sformatf("%s_wait_cycles", tag), n, 32'd4);
        check($sformatf("%s_flush_off", tag), {31'd0, bus.flush_o}, 32'd0);
        check($sformatf("%s_stall_off", tag), {31'd0, bus.stall_o}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_code", {27'd0, bus.exc_code_o}, {27'd0, EC_NONE});
        check("rst_epc", bus.exc_epc_o, 32'd0);
        check("rst_bva", bus.exc_badvaddr_o, 32'd0);
        check("rst_flush", {31'd0, bus.flush_o}, 32'd0);
        check("rst_stall", {31'd0, bus.stall_o}, 32'd0);
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Jump strobe while idle is ignored.
        bus.exc_jump_flag_i = 1'b1;
        @(negedge clk);
        bus.exc_jump_flag_i = 1'b0;
        check("idle_jump_busy", {31'd0, bus.busy_o}, 32'd0);

        // Single ID exception.
        set_stage(1, EC_SYS, 32'h8000_1008, 32'h0000_0000);
        push(EC_SYS, 32'h8000_1008, 32'h0);
        wait_issue("id_sys");
        clear_inputs();
        finish_jump("id_sys");

        // MEM overflow in a delay slot beats an IF address error.
        set_stage(3, EC_OV, 32'h8000_0100, 32'hDEAD_0000);
        set_stage(0, EC_ADEL, 32'h8000_0400, 32'h0000_1234);
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i = 32'h8000_0100;
        bus.mem_in_delay_slot_i = 1'b1;
        push(EC_OV, 32'h8000_00FC, 32'hDEAD_0000);
        wait_issue("mem_ov");
        clear_inputs();
        finish_timeout("mem_ov");

        // Interrupt beats an EX reserved-instruction exception.
        set_stage(2, EC_RI, 32'h8000_01F8, 32'h5555_0000);
        bus.has_int_i = 1'b1;
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i = 32'h8000_0200;
        push(EC_INT, 32'h8000_0200, 32'h0);
        wait_issue("int");
        clear_inputs();
        finish_jump("int");

        // Interrupt without a committable MEM instruction is not taken;
        // the EX exception wins.
        set_stage(2, EC_RI, 32'h8000_01F8, 32'h5555_0000);
        bus.has_int_i = 1'b1;
        push(EC_RI, 32'h8000_01F8, 32'h5555_0000);
        wait_issue("ex_ri");
        clear_inputs();
        finish_timeout("ex_ri");

        // ERET, then an IF request during WAIT_JUMP waits for IDLE.
        bus.eret_i = 1'b1;
        bus.mem_valid_i = 1'b1;
        push(EC_ERET, 32'h0, 32'h0);
        wait_issue("eret");
        clear_inputs();
        @(negedge clk);
        set_stage(0, EC_TLBL, 32'hBFC0_0000, 32'h0000_0044);
        push(EC_TLBL, 32'hBFC0_0000, 32'h0000_0044);
        check("eret_hold_w0", {27'd0, bus.exc_code_o}, {27'd0, EC_NONE});
        @(negedge clk);
        check("eret_hold_w1", {27'd0, bus.exc_code_o}, {27'd0, EC_NONE});
        bus.exc_jump_flag_i = 1'b1;
        @(negedge clk);
        bus.exc_jump_flag_i = 1'b0;
        check("eret_hold_f0", {27'd0, bus.exc_code_o}, {27'd0, EC_NONE});
        @(negedge clk);
        check("eret_hold_f1", {27'd0, bus.exc_code_o}, {27'd0, EC_NONE});
        wait_issue("if_tlbl");
        clear_inputs();
        finish_timeout("if_tlbl");

        // Delay-slot EPC wraps at PC 0.
        set_stage(3, EC_TLBL, 32'h0000_0000, 32'h0000_0008);
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i = 32'h0000_0000;
        bus.mem_in_delay_slot_i = 1'b1;
        push(EC_TLBL, 32'hFFFF_FFFC, 32'h0000_0008);
        wait_issue("wrap");
        clear_inputs();
        finish_timeout("wrap");

        // Reset asserted mid-FLUSH clears everything immediately.
        set_stage(1, EC_SYS, 32'h8000_2000, 32'h0);
        push(EC_SYS, 32'h8000_2000, 32'h0);
        wait_issue("rstmid");
        clear_inputs();
        @(negedge clk);
        bus.exc_jump_flag_i = 1'b1;
        @(negedge clk);
        bus.exc_jump_flag_i = 1'b0;
        check("rstmid_in_flush", {31'd0, bus.flush_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_flush", {31'd0, bus.flush_o}, 32'd0);
        check("rstmid_stall", {31'd0, bus.stall_o}, 32'd0);
        check("rstmid_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rstmid_code", {27'd0, bus.exc_code_o}, {27'd0, EC_NONE});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Collects exception requests from the IF/ID/EX/MEM pipeline stages, the pending-interrupt flag from the coprocessor-0 register file, and ERET, and picks one precise event per commit.
- Drives the one-cycle exception code/EPC/BadVAddr strobe into CP0, waits for CP0's jump response, then holds a pipeline flush/stall window before accepting new events.
- Sits between the MEM stage and CP0.

Parameters:
- FLUSH_CYCLES, 2, cycles the flush is held after CP0's jump strobe (1..15).
- ACK_TIMEOUT, 4, cycles to wait for exc_jump_flag_i before forcing return to IDLE (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- stage_valid_i  in  4  per-stage exception valid, bit3=MEM, 2=EX, 1=ID, 0=IF
- stage_code_i  in  20  5-bit exception code per stage, [19:15]=MEM … [4:0]=IF
- stage_pc_i  in  128  32-bit PC per stage, same ordering
- stage_badvaddr_i  in  128  32-bit faulting address per stage
- mem_valid_i  in  1  MEM holds a committable instruction
- mem_pc_i  in  32  PC of MEM instruction
- mem_in_delay_slot_i  in  1  MEM instruction is a branch delay slot
- eret_i  in  1  MEM instruction is ERET
- has_int_i  in  1  CP0 interrupt pending and enabled
- exc_jump_flag_i  in  1  CP0 redirect strobe
- exc_code_o  out  5  to CP0; EC_NONE when idle
- exc_epc_o  out  32  to CP0
- exc_badvaddr_o  out  32  to CP0
- flush_o  out  1  flush IF..MEM
- stall_o  out  1  freeze PC/commit while busy
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE, exc_code_o=EC_NONE, exc_epc_o=0, exc_badvaddr_o=0, flush_o=0, stall_o=0, busy_o=0, counters=0.
- States: IDLE, ISSUE, WAIT_JUMP, FLUSH.
- Selection happens in IDLE only, combinationally from the inputs and registered into the ISSUE outputs.
- Priority, highest first:
  - MEM exception (stage_valid_i[3]).
  - Interrupt (has_int_i && mem_valid_i), code EC_INT.
  - EX exception, then ID exception, then IF exception.
  - ERET (eret_i && mem_valid_i), code EC_ERET.
  - A stage exception is taken only if no older stage has one.
- EPC: the selected stage PC; for MEM/interrupt, mem_pc_i−4 if mem_in_delay_slot_i. For interrupts, EPC uses mem_pc_i. For ERET, EPC=0.
- BadVAddr: the selected stage's value; 0 for interrupt and ERET.
- IDLE → ISSUE when an event is selected. exc_code_o/epc/badvaddr are valid for exactly one cycle (ISSUE). flush_o=1 and stall_o=1 from ISSUE onward.
- ISSUE → WAIT_JUMP. exc_code_o returns to EC_NONE.
- WAIT_JUMP → FLUSH on exc_jump_flag_i=1. If ACK_TIMEOUT cycles pass without the strobe, go → IDLE and drop flush/stall.
- FLUSH: hold flush_o=stall_o=1 for FLUSH_CYCLES cycles, then → IDLE.
- Requests are ignored outside IDLE; they are not queued. Pipeline requests are re-presented after the flush.
- exc_jump_flag_i seen in IDLE is ignored.
- Reset asserted in any state returns to IDLE within the same cycle (async).
- PC arithmetic is 32-bit modulo. A delay-slot PC of 0 wraps to 0xFFFFFFFC.

Decomposition:
- Shared defines file holds EC_NONE=5'h1F, EC_ERET=5'h1E, EC_INT=5'h00, EC_TLBL=5'h02, EC_ADEL=5'h04, EC_SYS=5'h08, EC_RI=5'h0A, EC_OV=5'h0C, and the state encodings.
- One sub-module, exc_prio_sel: a combinational priority picker producing code/epc/badvaddr/hit from the stage vectors.

Test Plan:
- Single ID exception: stage_valid_i=4'b0010, code EC_SYS, pc 0x80001008 → one ISSUE cycle with exc_code_o=0x08, exc_epc_o=0x80001008. Jump strobe after 1 cycle → flush_o high for 2 cycles after the strobe, then busy_o=0.
- Simultaneous MEM EC_OV (pc 0x80000100, delay slot) and IF EC_ADEL → exc_code_o=0x0C, exc_epc_o=0x800000FC, exc_badvaddr_o=MEM value.
- has_int_i=1 with EX EC_RI and mem_pc_i=0x80000200 → exc_code_o=0x00, exc_epc_o=0x80000200, badvaddr=0.
- ERET with no other request → exc_code_o=0x1E. A new IF request during WAIT_JUMP is not issued until after IDLE.
- No exc_jump_flag_i → exactly 4 cycles in WAIT_JUMP, then IDLE with flush_o=0.
- Assert rst mid-FLUSH → flush_o, stall_o and busy_o go to 0 immediately, and exc_code_o=0x1F.
